hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised hazard and forwarding controller for the five-stage RV64 pipeline. It is the successor of the current two-source, stub-wired forwarding unit.
- Generalises forwarding to NUM_FWD downstream stages.
- Adds a load-use stall FSM with configurable LOAD_LATENCY.
- Adds taken-branch flush and a global external freeze.
- Sits beside the IF/ID and ID/EX registers. Drives PC_write, ifid_write, ctrl_hazard, the flushes and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register-address width
NUM_FWD, 2, number of forwarding source stages (index 0 = EX/MEM, nearest; NUM_FWD-1 = oldest)
LOAD_LATENCY, 1, load-use stall cycles (1..7)
SEL_W, $clog2(NUM_FWD+1), forward-select width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rs1_id, rs2_id  in  REG_ADDR_W each  source registers of the instruction in ID
use_rs1_id, use_rs2_id  in  1 each  ID instruction reads rs1 / rs2
rd_ex  in  REG_ADDR_W  destination of the instruction in EX
mem_read_ex  in  1  EX instruction is a load
rs1_ex, rs2_ex  in  REG_ADDR_W each  source registers in EX
fwd_rd  in  NUM_FWD*REG_ADDR_W  destination of each forwarding stage, flattened
fwd_reg_write  in  NUM_FWD  write-enable of each forwarding stage
branch_taken_ex  in  1  branch resolved taken in EX
ext_stall  in  1  memory busy; freeze the whole pipeline
forward_a, forward_b  out  SEL_W each  0 = register file; k = stage k-1
PC_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
idex_write  out  1  ID/EX register enable
ctrl_hazard  out  1  zero the control bits entering ID/EX (bubble)
flush_ifid, flush_idex  out  1 each  squash IF/ID / ID/EX contents

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State on reset: state=RUN, stall_cnt=0.
- Outputs while rst=1: forward_a=forward_b=0, PC_write=ifid_write=idex_write=1, ctrl_hazard=0, flush_ifid=flush_idex=0.
- Forwarding (combinational):
  - forward_a = k+1 for the lowest k with fwd_reg_write[k] && fwd_rd[k]==rs1_ex && rs1_ex!=0; otherwise 0. forward_b uses rs2_ex the same way.
  - The nearest stage wins. x0 is never forwarded.
- Load-use detect: hit = mem_read_ex && rd_ex!=0 && ((use_rs1_id && rs1_id==rd_ex) || (use_rs2_id && rs2_id==rd_ex)).
- FSM states: RUN, LOAD_STALL. stall_cnt is 3 bits.
  - RUN, hit, no branch, no ext_stall: stall this cycle. If LOAD_LATENCY>1, go to LOAD_STALL with stall_cnt=LOAD_LATENCY-1.
  - LOAD_STALL: stall each cycle; stall_cnt decrements; at stall_cnt==1 return to RUN.
- Stall outputs: PC_write=0, ifid_write=0, idex_write=1, ctrl_hazard=1. Total stall = exactly LOAD_LATENCY cycles per hit.
- Branch taken (ext_stall=0):
  - flush_ifid=flush_idex=1 for one cycle; PC_write=1.
  - Overrides a load stall: no stall that cycle, and the FSM returns to RUN with stall_cnt=0 (the dependent instruction is squashed).
- ext_stall=1 (highest priority):
  - PC_write=ifid_write=idex_write=0; ctrl_hazard=0; no flush.
  - FSM and stall_cnt hold.
  - A branch_taken_ex seen during ext_stall is acted on in the first cycle after ext_stall falls; EX is frozen, so the input stays high.
- Reset mid-stall: the next cycle is RUN with no stall.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles, flush_events, fwd_hits (32 bits each, saturating at 0xFFFFFFFF, cleared by rst).
  - stall_cycles: +1 per load-stall cycle.
  - flush_events: +1 per executed flush.
  - fwd_hits: +1 per cycle with a nonzero forward_a or forward_b.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg: state enum {RUN, LOAD_STALL}, the SEL_W computation, and the reset-value constants.
- Sub-module fwd_select: a parametrised priority matcher (rs, fwd_rd, fwd_reg_write -> sel). Instantiated twice, once for a and once for b.

Test Plan:
1. NUM_FWD=2, rs1_ex=5, fwd_rd={5,5}, both fwd_reg_write=1 -> forward_a=1 (nearest). Set fwd_reg_write[0]=0 -> forward_a=2. Set rs1_ex=0 -> forward_a=0.
2. LOAD_LATENCY=1, load rd_ex=7 in EX, ID has use_rs2_id=1 with rs2_id=7 -> one cycle PC_write=0, ifid_write=0, ctrl_hazard=1; next cycle back to normal.
3. LOAD_LATENCY=3, same hit -> exactly 3 stall cycles. With HAZARD_STATS_EN: stall_cycles=3.
4. Hit and branch_taken_ex in the same cycle -> flush_ifid=flush_idex=1, PC_write=1, no stall; the following cycle is RUN.
5. LOAD_LATENCY=3: ext_stall=1 for 4 cycles in the middle of the stall -> all enables 0, stall_cnt frozen; after release the remaining stall cycles complete; total 3 stall cycles.
6. rst asserted while in LOAD_STALL -> next cycle shows reset outputs. With HAZARD_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Contents: FSM state enum, forward-select width helper, reset-value constants.
package hazard_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_e;

  // Select 0 means "register file", 1..n pick a forwarding stage.
  function automatic int sel_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

  // Output values while rst is high: pipeline free-running, no bubble, no squash.
  localparam logic RST_PC_WRITE    = 1'b1;
  localparam logic RST_IFID_WRITE  = 1'b1;
  localparam logic RST_IDEX_WRITE  = 1'b1;
  localparam logic RST_CTRL_HAZARD = 1'b0;
  localparam logic RST_FLUSH       = 1'b0;
  localparam logic [2:0] RST_STALL_CNT = 3'd0;

endpackage

// File: rtl/fwd_select.sv
// Priority matcher choosing the nearest forwarding stage that writes rs.
// Ports: rs (source reg), fwd_rd (flattened stage destinations),
//        fwd_reg_write (stage write enables) -> sel (0 = regfile, k+1 = stage k).
module fwd_select #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_FWD    = 2,
  parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_ADDR_W-1:0]         rs,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]            fwd_reg_write,
  output logic [SEL_W-1:0]              sel
);

  // Walk oldest to nearest so the nearest match is the last write and wins.
  // x0 is hard-wired zero and must never be forwarded.
  always_comb begin
    sel = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_reg_write[k] && (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs) && (rs != '0)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the five-stage pipeline: EX operand
// forwarding, load-use stall FSM, taken-branch flush and external freeze.
// Ports: ID/EX register ids in, forwarding stage rd/write-enables in, branch_taken_ex,
//        ext_stall in; forward_a/b, PC_write, ifid_write, idex_write, ctrl_hazard,
//        flush_ifid, flush_idex out. Define HAZARD_STATS_EN for the
//        stall_cycles / flush_events / fwd_hits counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_FWD      = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int SEL_W        = sel_width(NUM_FWD)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_ADDR_W-1:0]         rs1_id,
  input  logic [REG_ADDR_W-1:0]         rs2_id,
  input  logic                          use_rs1_id,
  input  logic                          use_rs2_id,
  input  logic [REG_ADDR_W-1:0]         rd_ex,
  input  logic                          mem_read_ex,
  input  logic [REG_ADDR_W-1:0]         rs1_ex,
  input  logic [REG_ADDR_W-1:0]         rs2_ex,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]            fwd_reg_write,
  input  logic                          branch_taken_ex,
  input  logic                          ext_stall,
  output logic [SEL_W-1:0]              forward_a,
  output logic [SEL_W-1:0]              forward_b,
  output logic                          PC_write,
  output logic                          ifid_write,
  output logic                          idex_write,
  output logic                          ctrl_hazard,
  output logic                          flush_ifid,
  output logic                          flush_idex
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   flush_events,
  output logic [31:0]                   fwd_hits
`endif
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LATENCY - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic       hit;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_a (
    .rs(rs1_ex), .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write), .sel(sel_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_b (
    .rs(rs2_ex), .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write), .sel(sel_b)
  );

  assign hit = mem_read_ex && (rd_ex != '0) &&
               ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= RST_STALL_CNT;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Priority: ext_stall freezes everything, then a taken branch squashes
  // (cancelling any load stall, since the dependent instruction dies), then
  // an in-progress stall, then a fresh load-use hit.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    PC_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ctrl_hazard = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    forward_a   = sel_a;
    forward_b   = sel_b;

    if (ext_stall) begin
      PC_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (branch_taken_ex) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      state_d     = RUN;
      stall_cnt_d = 3'd0;
    end else if (state_q == LOAD_STALL) begin
      PC_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_hazard = 1'b1;
      if (stall_cnt_q <= 3'd1) begin
        state_d     = RUN;
        stall_cnt_d = 3'd0;
      end else begin
        stall_cnt_d = stall_cnt_q - 3'd1;
      end
    end else if (hit) begin
      PC_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_hazard = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_d     = LOAD_STALL;
        stall_cnt_d = LAT_M1;
      end
    end

    if (rst) begin
      PC_write    = RST_PC_WRITE;
      ifid_write  = RST_IFID_WRITE;
      idex_write  = RST_IDEX_WRITE;
      ctrl_hazard = RST_CTRL_HAZARD;
      flush_ifid  = RST_FLUSH;
      flush_idex  = RST_FLUSH;
      forward_a   = '0;
      forward_b   = '0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
      fwd_hits     <= '0;
    end else begin
      if (ctrl_hazard && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (flush_ifid && (flush_events != '1)) flush_events <= flush_events + 32'd1;
      if (((forward_a != '0) || (forward_b != '0)) && (fwd_hits != '1))
        fwd_hits <= fwd_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int W    = 5;
  localparam int NF   = 2;
  localparam int SELW = 2;

  // {PC_write, ifid_write, idex_write, ctrl_hazard, flush_ifid, flush_idex}
  localparam logic [5:0] NORM   = 6'b111000;
  localparam logic [5:0] STALL  = 6'b001100;
  localparam logic [5:0] FLUSH  = 6'b111011;
  localparam logic [5:0] FREEZE = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] rs1_id = '0, rs2_id = '0, rd_ex = '0, rs1_ex = '0, rs2_ex = '0;
  logic use_rs1_id = 1'b0, use_rs2_id = 1'b0, mem_read_ex = 1'b0;
  logic [NF*W-1:0] fwd_rd = '0;
  logic [NF-1:0] fwd_reg_write = '0;
  logic branch_taken_ex = 1'b0, ext_stall = 1'b0;

  logic [SELW-1:0] fa [2];
  logic [SELW-1:0] fb [2];
  logic [5:0] ctl [2];
  logic pcw [2], ifw [2], idw [2], chz [2], fif [2], fid [2];
`ifdef HAZARD_STATS_EN
  logic [31:0] st_cyc [2], fl_ev [2], fw_hit [2];
`endif

  always #5 clk = ~clk;

  // dut 0: LOAD_LATENCY=3, dut 1: LOAD_LATENCY=1; both see the same inputs.
  hazard_ctrl_unit #(.REG_ADDR_W(W), .NUM_FWD(NF), .LOAD_LATENCY(3)) dut0 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write),
    .branch_taken_ex(branch_taken_ex), .ext_stall(ext_stall),
    .forward_a(fa[0]), .forward_b(fb[0]), .PC_write(pcw[0]),
    .ifid_write(ifw[0]), .idex_write(idw[0]), .ctrl_hazard(chz[0]),
    .flush_ifid(fif[0]), .flush_idex(fid[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(st_cyc[0]), .flush_events(fl_ev[0]), .fwd_hits(fw_hit[0])
`endif
  );

  hazard_ctrl_unit #(.REG_ADDR_W(W), .NUM_FWD(NF), .LOAD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write),
    .branch_taken_ex(branch_taken_ex), .ext_stall(ext_stall),
    .forward_a(fa[1]), .forward_b(fb[1]), .PC_write(pcw[1]),
    .ifid_write(ifw[1]), .idex_write(idw[1]), .ctrl_hazard(chz[1]),
    .flush_ifid(fif[1]), .flush_idex(fid[1])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(st_cyc[1]), .flush_events(fl_ev[1]), .fwd_hits(fw_hit[1])
`endif
  );

  always_comb begin
    for (int i = 0; i < 2; i++) ctl[i] = {pcw[i], ifw[i], idw[i], chz[i], fif[i], fid[i]};
  end

  typedef struct {
    string           name;
    int              dut;
    logic [5:0]      ctl;
    logic [SELW-1:0] fa;
    logic [SELW-1:0] fb;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    tests++;
    if (ctl[e.dut] !== e.ctl || fa[e.dut] !== e.fa || fb[e.dut] !== e.fb) begin
      fails++;
      $display("FAIL %s dut%0d: got ctl=%b fa=%0d fb=%0d, want ctl=%b fa=%0d fb=%0d",
               e.name, e.dut, ctl[e.dut], fa[e.dut], fb[e.dut], e.ctl, e.fa, e.fb);
    end
  endtask

  // Inputs are set just after a rising edge; expectation queued, checked at negedge.
  task automatic step(input string name, input int dut, input logic [5:0] c,
                      input logic [SELW-1:0] ea, input logic [SELW-1:0] eb);
    exp_t e;
    e.name = name; e.dut = dut; e.ctl = c; e.fa = ea; e.fb = eb;
    sb.push_back(e);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rd_ex = '0; rs1_ex = '0; rs2_ex = '0;
    use_rs1_id = 0; use_rs2_id = 0; mem_read_ex = 0;
    fwd_rd = '0; fwd_reg_write = '0; branch_taken_ex = 0; ext_stall = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step("reset", 0, NORM, 0, 0);
    rst = 1'b0;
  endtask

  task automatic load_hit_rs2();
    mem_read_ex = 1; rd_ex = 7; use_rs2_id = 1; rs2_id = 7; use_rs1_id = 0; rs1_id = 3;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]    rs1, rs2, rd0, rd1;
    logic [NF-1:0]   wr;
    logic [SELW-1:0] ea, eb;
  } fvec_t;

  fvec_t fv[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    fv[0] = '{5'd5,  5'd0,  5'd5, 5'd5, 2'b11, 2'd1, 2'd0};
    fv[1] = '{5'd5,  5'd0,  5'd5, 5'd5, 2'b10, 2'd2, 2'd0};
    fv[2] = '{5'd0,  5'd0,  5'd0, 5'd0, 2'b11, 2'd0, 2'd0};
    fv[3] = '{5'd5,  5'd5,  5'd5, 5'd5, 2'b00, 2'd0, 2'd0};
    fv[4] = '{5'd3,  5'd9,  5'd9, 5'd3, 2'b11, 2'd2, 2'd1};
    fv[5] = '{5'd4,  5'd4,  5'd4, 5'd6, 2'b01, 2'd1, 2'd1};
    fv[6] = '{5'd31, 5'd30, 5'd1, 5'd2, 2'b11, 2'd0, 2'd0};

    @(posedge clk); #1;

    // Reset outputs, with matching forwarding inputs that must be masked.
    rs1_ex = 5; rs2_ex = 5; fwd_rd = {5'd5, 5'd5}; fwd_reg_write = 2'b11;
    step("reset_outputs", 0, NORM, 0, 0);
    step("reset_outputs", 1, NORM, 0, 0);
    do_reset();

    // Forwarding table.
    foreach (fv[i]) begin
      rs1_ex = fv[i].rs1; rs2_ex = fv[i].rs2;
      fwd_rd = {fv[i].rd1, fv[i].rd0}; fwd_reg_write = fv[i].wr;
      step($sformatf("fwd_vec%0d", i), i % 2, NORM, fv[i].ea, fv[i].eb);
    end
    clear_inputs();

    // No hit: load to x0, and a matching rs2 that is not used.
    mem_read_ex = 1; rd_ex = 0; use_rs1_id = 1; rs1_id = 0;
    step("load_x0_no_stall", 0, NORM, 0, 0);
    load_hit_rs2(); use_rs2_id = 0;
    step("unused_rs2_no_stall", 1, NORM, 0, 0);
    clear_inputs();

    // LOAD_LATENCY=1: a single stall cycle.
    do_reset();
    load_hit_rs2();
    step("lat1_stall", 1, STALL, 0, 0);
    clear_inputs();
    step("lat1_resume", 1, NORM, 0, 0);

    // LOAD_LATENCY=3: exactly three stall cycles.
    do_reset();
    load_hit_rs2();
    step("lat3_stall1", 0, STALL, 0, 0);
    clear_inputs();
    step("lat3_stall2", 0, STALL, 0, 0);
    step("lat3_stall3", 0, STALL, 0, 0);
`ifdef HAZARD_STATS_EN
    check_val("stats_stall_cycles", st_cyc[0], 32'd3);
`endif
    step("lat3_resume", 0, NORM, 0, 0);

    // Hit together with a taken branch: flush, no stall, then RUN.
    do_reset();
    load_hit_rs2(); branch_taken_ex = 1;
    step("hit_branch_flush", 0, FLUSH, 0, 0);
    clear_inputs();
    step("hit_branch_after", 0, NORM, 0, 0);

    // Branch during LOAD_STALL cancels the remaining stall.
    do_reset();
    load_hit_rs2();
    step("stall_then_branch_s1", 0, STALL, 0, 0);
    clear_inputs(); branch_taken_ex = 1;
    step("stall_branch_flush", 0, FLUSH, 0, 0);
    branch_taken_ex = 0;
    step("stall_branch_after", 0, NORM, 0, 0);

    // ext_stall for 4 cycles inside a 3-cycle load stall.
    do_reset();
    load_hit_rs2();
    step("ext_stall1", 0, STALL, 0, 0);
    clear_inputs();
    step("ext_stall2", 0, STALL, 0, 0);
    ext_stall = 1;
    for (int i = 0; i < 4; i++) step($sformatf("ext_freeze%0d", i), 0, FREEZE, 0, 0);
    ext_stall = 0;
    step("ext_stall3", 0, STALL, 0, 0);
    step("ext_resume", 0, NORM, 0, 0);

    // Branch held high under ext_stall is acted on after release.
    ext_stall = 1; branch_taken_ex = 1;
    step("ext_branch_frozen", 0, FREEZE, 0, 0);
    ext_stall = 0;
    step("ext_branch_flush", 0, FLUSH, 0, 0);
    branch_taken_ex = 0;
    step("ext_branch_after", 0, NORM, 0, 0);

    // Reset in the middle of LOAD_STALL.
    do_reset();
    load_hit_rs2();
    step("rst_mid_s1", 0, STALL, 0, 0);
    rst = 1;
    step("rst_mid_reset", 0, NORM, 0, 0);
    rst = 0; clear_inputs();
`ifdef HAZARD_STATS_EN
    check_val("stats_cleared_stall", st_cyc[0], 32'd0);
    check_val("stats_cleared_flush", fl_ev[0], 32'd0);
    check_val("stats_cleared_fwd", fw_hit[0], 32'd0);
`endif
    step("rst_mid_run", 0, NORM, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
